// File: rtl/count_pwm_gen.sv
// -----------------------------------------------------------------------------
// count_pwm_gen
//
// Turns the free-running count of an upstream WIDTH-bit up-counter into a
// registered PWM waveform. The duty value arrives over a valid/ready handshake
// and is held in a shadow register. It is copied into the active compare
// register only at a period boundary, so the output never changes shape in
// the middle of a period.
//
// Ports:
//   clk          system clock, rising edge (same clock as the upstream counter)
//   clear_n      asynchronous active-low reset
//   cnt          count from the upstream counter (wraps 2^WIDTH-1 -> 0)
//   enable       run request; sampled only at period boundaries
//   duty         requested high time in clocks, 0..2^WIDTH (larger saturates)
//   duty_valid   duty is presented
//   duty_ready   shadow register is free; transfer when valid && ready
//   pwm_out      registered PWM output (1 clock latency from cnt)
//   pwm_out_n    complementary output with dead time (PWM_COMPL_EN only)
//   period_tick  one-cycle pulse, the cycle after each detected boundary
//   running      high while in RUN
//
// Build option:
//   PWM_COMPL_EN  adds pwm_out_n and per-output dead-time down-counters.
//                 Each rising edge is held off DEADTIME clocks after the
//                 other output falls. Falling edges are never delayed.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs held low, waiting for a boundary with enable=1
// RUN   | pwm_out follows (cnt < active duty) every clock
// -----------------------------------------------------------------------------
module count_pwm_gen #(
    parameter int WIDTH    = 4,
    parameter int DEADTIME = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] cnt,
    input  logic             enable,
    input  logic [WIDTH:0]   duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
`ifdef PWM_COMPL_EN
    output logic             pwm_out_n,
`endif
    output logic             period_tick,
    output logic             running
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH-1:0] cnt_prev_q, cnt_prev_d;
    logic             period_tick_q, period_tick_d;
    logic             state_q, state_d;
    logic             pending_q, pending_d;
    logic [WIDTH:0]   shadow_q, shadow_d;
    logic [WIDTH:0]   active_q, active_d;
    logic             pwm_q, pwm_d;

    logic boundary;
    logic accept;
    logic load;
    logic cmp_hi;
    logic raw_hi;
    logic raw_lo;

    always_comb begin
        // An upstream counter held at 0 gives one boundary and then none.
        // An early clear back to 0 still counts as a boundary.
        boundary = (cnt == '0) && (cnt_prev_q != '0);
        accept   = duty_valid && !pending_q;
        load     = boundary && pending_q;

        cnt_prev_d    = cnt;
        period_tick_d = boundary;

        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (load) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = (duty > DUTY_MAX) ? DUTY_MAX : duty;
            pending_d = 1'b1;
        end

        state_d = state_q;
        if (boundary) begin
            state_d = enable ? ST_RUN : ST_IDLE;
        end

        // The compare uses the next-cycle duty and state, so a duty loaded at
        // the boundary already shapes the cnt=0 sample.
        cmp_hi = ({1'b0, cnt} < active_d);
        raw_hi = (state_d == ST_RUN) && cmp_hi;
        raw_lo = (state_d == ST_RUN) && !cmp_hi;
    end

`ifdef PWM_COMPL_EN
    localparam logic       DT_ON   = (DEADTIME > 0);
    localparam logic [1:0] DT_LOAD = (DEADTIME > 0) ? 2'(DEADTIME - 1) : 2'd0;

    logic       pwm_n_q, pwm_n_d;
    logic [1:0] dt_p_q, dt_p_d;
    logic [1:0] dt_n_q, dt_n_d;
    logic       p_fall, n_fall;
    logic       blk_p, blk_n;

    always_comb begin
        // The two outputs are never high together, so a high output can only
        // fall when its own raw compare drops. This keeps the fall detect
        // free of any loop through the other output's blocking.
        p_fall = pwm_q && !raw_hi;
        n_fall = pwm_n_q && !raw_lo;

        // The fall cycle itself is the first blocked clock. The counter then
        // covers the remaining DEADTIME-1 clocks.
        blk_p  = n_fall ? DT_ON : (dt_p_q != 2'd0);
        blk_n  = p_fall ? DT_ON : (dt_n_q != 2'd0);
        dt_p_d = n_fall ? DT_LOAD : ((dt_p_q != 2'd0) ? dt_p_q - 2'd1 : 2'd0);
        dt_n_d = p_fall ? DT_LOAD : ((dt_n_q != 2'd0) ? dt_n_q - 2'd1 : 2'd0);

        pwm_d   = raw_hi && !blk_p;
        pwm_n_d = raw_lo && !blk_n;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pwm_n_q <= 1'b0;
            dt_p_q  <= 2'd0;
            dt_n_q  <= 2'd0;
        end else begin
            pwm_n_q <= pwm_n_d;
            dt_p_q  <= dt_p_d;
            dt_n_q  <= dt_n_d;
        end
    end

    assign pwm_out_n = pwm_n_q;
`else
    // Without the complementary output, DEADTIME and the low-side compare
    // have no effect.
    logic unused_dt;
    assign unused_dt = (^DEADTIME) ^ raw_lo;

    always_comb begin
        pwm_d = raw_hi;
    end
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_prev_q    <= '1;
            period_tick_q <= 1'b0;
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            pwm_q         <= 1'b0;
        end else begin
            cnt_prev_q    <= cnt_prev_d;
            period_tick_q <= period_tick_d;
            state_q       <= state_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign duty_ready  = !pending_q;
    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;
    assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_count_pwm_gen.sv
`timescale 1ns/1ps
module tb_count_pwm_gen;

`ifdef PWM_COMPL_EN
    localparam int DT = 2;
`else
    localparam int DT = 1;
`endif

    logic       clk        = 1'b0;
    logic       clear_n    = 1'b0;
    logic [3:0] cnt        = 4'd0;
    logic       enable     = 1'b0;
    logic [4:0] duty       = 5'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_tick;
    logic       running;
    logic       pwm_out_n_s;

`ifdef PWM_COMPL_EN
    logic pwm_out_n;
    assign pwm_out_n_s = pwm_out_n;
`else
    assign pwm_out_n_s = 1'b0;
`endif

    count_pwm_gen #(.WIDTH(4), .DEADTIME(DT)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .cnt         (cnt),
        .enable      (enable),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
`ifdef PWM_COMPL_EN
        .pwm_out_n   (pwm_out_n),
`endif
        .period_tick (period_tick),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] exp;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Vector order everywhere: {pwm_out_n, pwm_out, period_tick, running, duty_ready}
    function automatic logic [4:0] outs();
        return {pwm_out_n_s, pwm_out, period_tick, running, duty_ready};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b {n,pwm,tick,run,rdy} t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a new output word after every active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.tag, outs(), e.exp);
        end
    end

    // Drive one cycle of inputs and queue what the outputs must show after the edge.
    task automatic step(input int c, input bit en, input bit v, input int d,
                        input bit e_n, input bit e_p, input bit e_t, input bit e_r,
                        input bit e_rdy, input string tag);
        exp_t e;
        @(negedge clk);
        cnt        = 4'(c);
        enable     = en;
        duty_valid = v;
        duty       = 5'(d);
        e.exp = {e_n, e_p, e_t, e_r, e_rdy};
        e.tag = $sformatf("%s c=%0d", tag, c);
        sb_q.push_back(e);
    endtask

    // One running period with active duty 'act'; optional writes at wr_c / wr2_c.
    task automatic period(input int act, input int wr_c, input int wr_v,
                          input int wr2_c, input int wr2_v, input string tag);
        bit v;
        int d;
        bit rdy;
        for (int c = 0; c < 16; c++) begin
            v   = (c == wr_c) || (c == wr2_c);
            d   = (c == wr2_c) ? wr2_v : wr_v;
            rdy = !(wr_c >= 0 && c >= wr_c);
            step(c, 1'b1, v, d, 1'b0, c < act, c == 0, 1'b1, rdy, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0;
        cnt     = 4'd10;
        enable  = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_state", outs(), 5'b00001);
        @(negedge clk);
        clear_n = 1'b1;

`ifdef PWM_COMPL_EN
        step(10, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "c_wr6");
        for (int c = 11; c < 16; c++)
            step(c, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "c_pre");
        // Entering RUN from IDLE: pwm_out_n was low, so pwm_out rises at once.
        for (int c = 0; c < 16; c++)
            step(c, 1'b1, 1'b0, 0, c >= 8, c < 6, c == 0, 1'b1, 1'b1, "c_first");
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 16; c++)
                step(c, 1'b1, 1'b0, 0, c >= 8, (c >= 2) && (c < 6), c == 0, 1'b1, 1'b1, "c_dead");
`else
        // Duty 4 accepted before the first boundary.
        step(10, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p1_wr4");
        for (int c = 11; c < 16; c++)
            step(c, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p1_pre");
        period(4, -1, 0, -1, 0, "p1_run");
        // 0 %, 100 %, and 31 saturating to 16.
        period(4, 5, 0, -1, 0, "p2_wr0");
        period(0, 5, 16, -1, 0, "p2_zero");
        period(16, 5, 31, -1, 0, "p2_full");
        // 31 took effect as 16; write 8, then 2 is refused while ready is low.
        period(16, 3, 8, 7, 2, "p3_sat");
        period(8, -1, 0, -1, 0, "p3_eight");
        // Upstream held in clear: one tick only, no load of the accepted 2.
        for (int h = 0; h < 20; h++)
            step(0, 1'b1, h == 5, 2, 1'b0, 1'b1, h == 0, 1'b1, h < 5, "p4_hold");
        for (int c = 1; c < 16; c++)
            step(c, 1'b1, 1'b0, 0, 1'b0, c < 8, 1'b0, 1'b1, 1'b0, "p4_resume");
        // Duty 2 loads here; enable drops after c=0 but RUN holds to the boundary.
        for (int c = 0; c < 16; c++)
            step(c, c == 0, 1'b0, 0, 1'b0, c < 2, c == 0, 1'b1, 1'b1, "p5_endrop");
        for (int c = 0; c < 16; c++)
            step(c, 1'b0, 1'b0, 0, 1'b0, 1'b0, c == 0, 1'b0, 1'b1, "p5_idle");
        step(0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "p5_rerun");
        step(1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "p5_rerun");
        // Async reset mid-period while pwm_out is high.
        @(posedge clk);
        #3 clear_n = 1'b0;
        #1 check("async_reset", outs(), 5'b00001);
        cnt = 4'd0;
        repeat (2) @(posedge clk);
        #3 clear_n = 1'b1;
        // cnt_prev resets to all ones, so the first cnt=0 is a boundary.
        step(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "p5_restart");
        for (int c = 1; c < 16; c++)
            step(c, 1'b1, c == 3, 4, 1'b0, 1'b0, 1'b0, 1'b1, c < 3, "p5_restart");
        period(4, -1, 0, -1, 0, "p5_after");
`endif

        @(posedge clk);
        #2 check("sb_drain", 5'(sb_q.size()), 5'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
